// File: rtl/alu_sequencer.sv
// alu_sequencer: two-cycle FETCH/EXEC program sequencer for a 4-bit ALU datapath.
// In: clk, reset (sync, low), start, prog_we/addr/data, c_in, z_in.
// Out: accu_en, bus1_en, bus2_en, in_bus1, Sel, pc, busy, done, error.
module alu_sequencer #(
  parameter int ADDR_W   = 4,
  parameter int WATCHDOG = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
  input  logic              c_in,
  input  logic              z_in,
  output logic              accu_en,
  output logic              bus1_en,
  output logic              bus2_en,
  output logic [3:0]        in_bus1,
  output logic [2:0]        Sel,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int SW = $clog2(WATCHDOG + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        ir;
  logic              flag_c;
  logic              flag_z;
  logic              ran;
  logic [SW-1:0]     steps;

  logic              alu_op;
  logic              halt;
  logic              taken;
  logic              wd_hit;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;

  assign alu_op = ~ir[7];
  assign halt   = ir[7] & (ir[6:5] == 2'b00);
  assign target = ADDR_W'(ir[3:0]);
  assign pc_inc = pc + ADDR_W'(1);
  // this EXEC is the last one the watchdog allows
  assign wd_hit = (steps == SW'(WATCHDOG - 1));

  always_comb begin
    taken = 1'b0;
    case (ir[6:5])
      2'b01:   taken = 1'b1;
      2'b10:   taken = flag_z;
      2'b11:   taken = flag_c;
      default: taken = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = EXEC;
      EXEC:    state_nx = (halt | wd_hit) ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: decode of state and ir only
  always_comb begin
    accu_en = 1'b0;
    bus1_en = 1'b0;
    in_bus1 = 4'd0;
    Sel     = 3'd0;
    busy    = (state == FETCH) || (state == EXEC);
    done    = (state == DONE);
    bus2_en = ran;
    if (state == EXEC && alu_op) begin
      accu_en = 1'b1;
      bus1_en = 1'b1;
      Sel     = ir[6:4];
      in_bus1 = ir[3:0];
    end
  end

  // program RAM survives reset
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && prog_we)
      mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc     <= '0;
      ir     <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      steps  <= '0;
      error  <= 1'b0;
      ran    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc     <= '0;
            steps  <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            error  <= 1'b0;
            ran    <= 1'b1;
          end
        end
        FETCH: ir <= mem[pc];
        EXEC: begin
          steps <= steps + SW'(1);
          if (wd_hit) error <= 1'b1;
          if (alu_op) begin
            flag_c <= c_in;
            flag_z <= z_in;
            pc     <= pc_inc;
          end else if (!halt) begin
            pc <= taken ? target : pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus randomized programs checked
// against an instruction-level reference interpreter.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'd0;
  logic       c_in = 1'b0;
  logic       z_in = 1'b0;
  logic       accu_en, bus1_en, bus2_en;
  logic [3:0] in_bus1;
  logic [2:0] Sel;
  logic [3:0] pc;
  logic       busy, done, error;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .c_in(c_in), .z_in(z_in),
    .accu_en(accu_en), .bus1_en(bus1_en), .bus2_en(bus2_en),
    .in_bus1(in_bus1), .Sel(Sel), .pc(pc),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       accu_en;
    logic       bus1_en;
    logic       bus2_en;
    logic [2:0] sel;
    logic [3:0] in_bus1;
    logic       busy;
    logic       done;
    logic [3:0] pc;
    logic       err;
  } obs_t;

  typedef struct {
    string      name;
    logic [7:0] p0, p1, p2, p3, fill;
    bit         c, z;
    int         dcyc;
    logic [3:0] fpc;
    logic       ferr;
  } vec_t;

  obs_t       exp_q[$];
  bit         cv[256];
  bit         zv[256];
  int         m_pc;
  bit         m_err;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {accu_en, bus1_en, bus2_en, Sel, in_bus1, busy, done, pc, error};
    return o;
  endfunction

  function automatic obs_t mk(bit a, bit b, logic [2:0] s, logic [3:0] ib,
                              bit bz, bit dn, int p, bit e);
    obs_t o;
    o.accu_en = a;
    o.bus1_en = b;
    o.bus2_en = 1'b1;
    o.sel     = s;
    o.in_bus1 = ib;
    o.busy    = bz;
    o.done    = dn;
    o.pc      = 4'(p);
    o.err     = e;
    return o;
  endfunction

  // Instruction interpreter: one FETCH and one EXEC cycle per instruction,
  // flags taken from the inputs present during that instruction's EXEC.
  task automatic build_model(input logic [7:0] p[16]);
    int         pcm = 0;
    int         steps = 0;
    int         cyc = 1;
    bit         fc = 0, fz = 0, err = 0, stop = 0;
    logic [7:0] ins;
    exp_q.delete();
    while (!stop) begin
      exp_q.push_back(mk(0, 0, 3'd0, 4'd0, 1, 0, pcm, 0));
      cyc++;
      ins = p[pcm];
      if (!ins[7]) exp_q.push_back(mk(1, 1, ins[6:4], ins[3:0], 1, 0, pcm, 0));
      else         exp_q.push_back(mk(0, 0, 3'd0, 4'd0, 1, 0, pcm, 0));
      steps++;
      if (!ins[7]) begin
        fc  = cv[cyc];
        fz  = zv[cyc];
        pcm = (pcm + 1) % 16;
      end else begin
        case (ins[6:5])
          2'd0: stop = 1;
          2'd1: pcm = int'(ins[3:0]);
          2'd2: pcm = fz ? int'(ins[3:0]) : (pcm + 1) % 16;
          default: pcm = fc ? int'(ins[3:0]) : (pcm + 1) % 16;
        endcase
      end
      cyc++;
      if (steps == 64) begin
        err  = 1;
        stop = 1;
      end
    end
    exp_q.push_back(mk(0, 0, 3'd0, 4'd0, 0, 1, pcm, err));
    m_pc  = pcm;
    m_err = err;
  endtask

  task automatic run(input logic [7:0] p[16], input bit load, input bit wr0,
                     input bit rnd, input bit c0, input bit z0, input bit noise,
                     output int dcyc, output logic [3:0] fpc, output logic ferr);
    for (int i = 0; i < 256; i++) begin
      cv[i] = rnd ? bit'($urandom % 2) : c0;
      zv[i] = rnd ? bit'($urandom % 2) : z0;
    end
    build_model(p);
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 4'(i);
        prog_data = p[i];
      end
    end
    @(negedge clk);
    prog_we   = wr0;
    prog_addr = 4'd0;
    prog_data = p[0];
    start     = 1'b1;
    dcyc = -1;
    fpc  = 4'd0;
    ferr = 1'b0;
    for (int j = 1; j < 200; j++) begin
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
      if (j <= exp_q.size())
        check($sformatf("trace_cyc%0d", j), 32'(sample()), 32'(exp_q[j-1]));
      c_in = cv[j];
      z_in = zv[j];
      if (noise) begin
        start     = 1'($urandom % 2);
        prog_we   = 1'($urandom % 2);
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
      end
      if (done) begin
        dcyc = j;
        fpc  = pc;
        ferr = error;
        break;
      end
    end
    start   = 1'b0;
    prog_we = 1'b0;
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done expected done by cycle %0d",
               exp_q.size());
    end
  endtask

  function automatic void mkprog(input vec_t v, output logic [7:0] p[16]);
    for (int i = 0; i < 16; i++) p[i] = v.fill;
    p[0] = v.p0;
    p[1] = v.p1;
    p[2] = v.p2;
    p[3] = v.p3;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[7];
    logic [7:0] p[16];
    int         dc;
    logic [3:0] fp;
    logic       fe;

    vecs[0] = '{"alu2",   8'h31, 8'h31, 8'h80, 8'h80, 8'h80, 0, 0,   7, 4'd2, 1'b0};
    vecs[1] = '{"jz_tk",  8'h00, 8'hC3, 8'h80, 8'h80, 8'h80, 0, 1,   7, 4'd3, 1'b0};
    vecs[2] = '{"jz_nt",  8'h00, 8'hC3, 8'h80, 8'h80, 8'h80, 0, 0,   7, 4'd2, 1'b0};
    vecs[3] = '{"jc_tk",  8'h00, 8'hE3, 8'h80, 8'h80, 8'h80, 1, 0,   7, 4'd3, 1'b0};
    vecs[4] = '{"jc_nt",  8'h00, 8'hE3, 8'h80, 8'h80, 8'h80, 0, 0,   7, 4'd2, 1'b0};
    vecs[5] = '{"wdog",   8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'h80, 0, 0, 129, 4'd0, 1'b1};
    vecs[6] = '{"wrap",   8'hE3, 8'hAE, 8'h80, 8'h80, 8'h21, 1, 0,  13, 4'd3, 1'b0};

    // reset held for two edges
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(sample()), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      mkprog(vecs[i], p);
      run(p, 1, 0, 0, vecs[i].c, vecs[i].z, 0, dc, fp, fe);
      check({vecs[i].name, "_dcyc"}, 32'(dc), 32'(vecs[i].dcyc));
      check({vecs[i].name, "_pc"}, 32'(fp), 32'(vecs[i].fpc));
      check({vecs[i].name, "_err"}, 32'(fe), 32'(vecs[i].ferr));
      @(negedge clk);
      check({vecs[i].name, "_idle"}, 32'({busy, done, bus2_en, error}),
            32'({1'b0, 1'b0, 1'b1, vecs[i].ferr}));
    end

    // reset keeps RAM: rerun resident wrap program without loading
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset2_outs", 32'(sample()), 32'd0);
    reset = 1'b1;
    mkprog(vecs[6], p);
    run(p, 0, 0, 0, 1, 0, 0, dc, fp, fe);
    check("resident_dcyc", 32'(dc), 32'd13);
    check("resident_pc", 32'(fp), 32'd3);

    // reset during an ALU EXEC
    mkprog(vecs[0], p);
    run(p, 1, 0, 0, 0, 0, 0, dc, fp, fe);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_exec_accu", 32'({accu_en, busy}), 32'({1'b1, 1'b1}));
    reset = 1'b0;
    @(negedge clk);
    check("abort_outs", 32'(sample()), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), 32'({busy, done}), 32'd0);
    end
    run(p, 0, 0, 0, 0, 0, 0, dc, fp, fe);
    check("after_abort_dcyc", 32'(dc), 32'd7);
    check("after_abort_pc", 32'(fp), 32'd2);

    // prog_we and start together: new instruction at addr 0 runs first
    p[0] = 8'h80;
    run(p, 0, 1, 0, 0, 0, 0, dc, fp, fe);
    check("simul_dcyc", 32'(dc), 32'd3);
    check("simul_pc", 32'(fp), 32'd0);

    // writes and starts while busy are ignored
    mkprog(vecs[0], p);
    run(p, 1, 0, 0, 0, 0, 1, dc, fp, fe);
    check("noise_dcyc", 32'(dc), 32'd7);
    run(p, 0, 0, 1, 0, 0, 1, dc, fp, fe);
    check("noise_rerun_dcyc", 32'(dc), 32'd7);

    // random programs and flags
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
      run(p, 1, 0, 1, 0, 0, 1, dc, fp, fe);
      check($sformatf("rnd%0d_dcyc", r), 32'(dc), 32'(exp_q.size()));
      check($sformatf("rnd%0d_pc", r), 32'(fp), 32'(m_pc));
      check($sformatf("rnd%0d_err", r), 32'(fe), 32'(m_err));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
